// File: rtl/reg_writeback.sv
// Writeback buffer: in-order queue merging ALU and load results into the
// register file write port, with a two-port bypass lookup over pending entries.
module reg_writeback #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_addr,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     ld_ready,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_addr,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  output logic                     wr_en,
  output logic [4:0]               wr_addr,
  output logic [XLEN-1:0]          wr_data,
  input  logic [4:0]               read1,
  input  logic [4:0]               read2,
  output logic                     byp1_hit,
  output logic                     byp2_hit,
  output logic [XLEN-1:0]          byp1_data,
  output logic [XLEN-1:0]          byp2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   rd_ptr, wr_ptr, alu_slot, idx;
  logic [CW-1:0]   cnt_q, free;
  logic [4:0]      q_addr [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic            ld_store, alu_store, deq;

  // Readiness is derived from the registered count only; a same-cycle pop
  // never opens a slot for a producer.
  assign free      = CW'(DEPTH) - cnt_q;
  assign ld_ready  = (free >= CW'(1));
  assign alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~ld_valid);

  assign ld_store  = ld_valid  & ld_ready  & (ld_addr  != 5'd0);
  assign alu_store = alu_valid & alu_ready & (alu_addr != 5'd0);
  assign deq       = (cnt_q != '0);
  assign alu_slot  = wr_ptr + PW'(ld_store);

  assign count   = cnt_q;
  assign full    = (cnt_q == CW'(DEPTH));
  assign wr_en   = deq;
  assign wr_addr = deq ? q_addr[rd_ptr] : '0;
  assign wr_data = deq ? q_data[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(deq);
      wr_ptr <= wr_ptr + PW'(ld_store) + PW'(alu_store);
      cnt_q  <= cnt_q + CW'(ld_store) + CW'(alu_store) - CW'(deq);
    end
  end

  // Storage needs no reset: outputs are gated by the occupied count.
  always_ff @(posedge clk) begin
    if (ld_store) begin
      q_addr[wr_ptr] <= ld_addr;
      q_data[wr_ptr] <= ld_data;
    end
    if (alu_store) begin
      q_addr[alu_slot] <= alu_addr;
      q_data[alu_slot] <= alu_data;
    end
  end

  // Scan oldest to youngest so the last match found is the youngest.
  always_comb begin
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < cnt_q) begin
        if ((read1 != 5'd0) && (q_addr[idx] == read1)) begin
          byp1_hit  = 1'b1;
          byp1_data = q_data[idx];
        end
        if ((read2 != 5'd0) && (q_addr[idx] == read2)) begin
          byp2_hit  = 1'b1;
          byp2_data = q_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_reg_writeback;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ld_valid, alu_valid;
  logic [4:0]      ld_addr, alu_addr, read1, read2;
  logic [XLEN-1:0] ld_data, alu_data;
  logic            ld_ready, alu_ready, wr_en, byp1_hit, byp2_hit, full;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data, byp1_data, byp2_data;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  reg_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .read1(read1), .read2(read2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
    .byp1_data(byp1_data), .byp2_data(byp2_data),
    .count(count), .full(full)
  );

  typedef struct {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t            mq[$];
  logic [XLEN-1:0] rf_m [32];
  logic [XLEN-1:0] rf_d [32];
  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic offer(input logic lv, input logic [4:0] la, input logic [XLEN-1:0] ldv,
                       input logic av, input logic [4:0] aa, input logic [XLEN-1:0] adv);
    ld_valid  = lv;  ld_addr  = la; ld_data  = ldv;
    alu_valid = av;  alu_addr = aa; alu_data = adv;
  endtask

  // One clock: compare every output against the model at the negedge, then
  // advance the model by the edge's retirement and acceptances.
  task automatic step();
    int              free;
    bit              eld, ealu, eh1, eh2;
    logic [XLEN-1:0] ed1, ed2;
    ent_t            e;
    @(negedge clk);
    free = DEPTH - mq.size();
    eld  = (free >= 1);
    ealu = (free >= 2) || (free == 1 && !ld_valid);
    check("ld_ready",  64'(ld_ready),  64'(eld));
    check("alu_ready", 64'(alu_ready), 64'(ealu));
    check("count",     64'(count),     64'(mq.size()));
    check("full",      64'(full),      64'(mq.size() == DEPTH));
    if (mq.size() != 0) begin
      check("wr_en",   64'(wr_en),   64'(1));
      check("wr_addr", 64'(wr_addr), 64'(mq[0].a));
      check("wr_data", 64'(wr_data), 64'(mq[0].d));
    end else begin
      check("wr_en",   64'(wr_en),   64'(0));
      check("wr_addr", 64'(wr_addr), 64'(0));
      check("wr_data", 64'(wr_data), 64'(0));
    end
    eh1 = 1'b0; eh2 = 1'b0; ed1 = '0; ed2 = '0;
    foreach (mq[i]) begin
      if (read1 != 0 && mq[i].a == read1) begin eh1 = 1'b1; ed1 = mq[i].d; end
      if (read2 != 0 && mq[i].a == read2) begin eh2 = 1'b1; ed2 = mq[i].d; end
    end
    check("byp1_hit",  64'(byp1_hit),  64'(eh1));
    check("byp1_data", 64'(byp1_data), 64'(ed1));
    check("byp2_hit",  64'(byp2_hit),  64'(eh2));
    check("byp2_data", 64'(byp2_data), 64'(ed2));
    if (wr_en) rf_d[wr_addr] = wr_data;
    @(posedge clk);
    if (mq.size() != 0) begin
      rf_m[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    if (ld_valid && eld && ld_addr != 0) begin
      e.a = ld_addr; e.d = ld_data; mq.push_back(e);
    end
    if (alu_valid && ealu && alu_addr != 0) begin
      e.a = alu_addr; e.d = alu_data; mq.push_back(e);
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin rf_m[i] = '0; rf_d[i] = '0; end
    rst_n = 1'b0;
    offer(0, 0, 0, 0, 0, 0);
    read1 = 5'd0; read2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en",     64'(wr_en),     64'(0));
    check("rst_count",     64'(count),     64'(0));
    check("rst_full",      64'(full),      64'(0));
    check("rst_ld_ready",  64'(ld_ready),  64'(1));
    check("rst_alu_ready", 64'(alu_ready), 64'(1));
    rst_n = 1'b1;

    // Single ALU result through an empty queue.
    offer(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    step();
    offer(0, 0, 0, 0, 0, 0);
    check("t1_wr_en",   64'(wr_en),   64'(1));
    check("t1_wr_addr", 64'(wr_addr), 64'(5));
    check("t1_wr_data", 64'(wr_data), 64'(32'hDEADBEEF));
    step();
    check("t1_count_after", 64'(count), 64'(0));
    check("t1_wr_en_after", 64'(wr_en), 64'(0));

    // Same destination from both sources: load is older.
    offer(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    step();
    offer(0, 0, 0, 0, 0, 0);
    read1 = 5'd3;
    #1;
    check("t2_byp1_hit",  64'(byp1_hit),  64'(1));
    check("t2_byp1_data", 64'(byp1_data), 64'(32'h22));
    check("t2_first",     64'(wr_data),   64'(32'h11));
    step();
    check("t2_second",    64'(wr_data),   64'(32'h22));
    step();
    read1 = 5'd0;

    // Build occupancy to DEPTH-1 (the head always retires), then offer both.
    offer(1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2);
    step();
    offer(1, 5'd6, 32'hB1, 1, 5'd7, 32'hB2);
    step();
    offer(1, 5'd8, 32'hC1, 1, 5'd9, 32'hC2);
    #1;
    check("t3_count",     64'(count),     64'(3));
    check("t3_ld_ready",  64'(ld_ready),  64'(1));
    check("t3_alu_ready", 64'(alu_ready), 64'(0));
    step();
    ld_valid = 1'b0;
    #1;
    check("t3_alu_ready_next", 64'(alu_ready), 64'(1));
    step();
    offer(0, 0, 0, 0, 0, 0);
    repeat (4) step();

    // x0 destination: handshake completes, nothing stored.
    offer(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
    read2 = 5'd0;
    step();
    offer(0, 0, 0, 0, 0, 0);
    check("t4_count",    64'(count),    64'(0));
    check("t4_wr_en",    64'(wr_en),    64'(0));
    check("t4_byp2_hit", 64'(byp2_hit), 64'(0));

    // Asynchronous reset with three entries pending.
    offer(1, 5'd10, 32'h100, 1, 5'd11, 32'h101);
    step();
    offer(1, 5'd12, 32'h102, 1, 5'd13, 32'h103);
    step();
    offer(0, 0, 0, 0, 0, 0);
    read1 = 5'd12;
    #1;
    check("t5_count_pre", 64'(count), 64'(3));
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_wr_en",     64'(wr_en),     64'(0));
    check("t5_count",     64'(count),     64'(0));
    check("t5_byp1_hit",  64'(byp1_hit),  64'(0));
    check("t5_byp1_data", 64'(byp1_data), 64'(0));
    mq.delete();
    rst_n = 1'b1;
    repeat (3) step();
    read1 = 5'd0;

    // Random traffic; small address range forces duplicates and bypass hits.
    for (int c = 0; c < 10000; c++) begin
      offer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      read1 = 5'($urandom_range(0, 7));
      read2 = 5'($urandom_range(0, 7));
      step();
    end
    offer(0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 1) step();
    for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), 64'(rf_d[i]), 64'(rf_m[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
